apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master_if.sv | 54 +++++
 rtl/apb_timeout_cnt.sv | 28 ++
 rtl/apb_master.sv | 98 +++++++++
 tb/tb_apb_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// APB master shared types and defaults.
// FSM states, bus widths and counter sizing.
package apb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals.
// master: the apb_master side; slave: the environment.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              PRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PRESETn, cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA,
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PRESETn, cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA,
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    output rsp_ready,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter.
// expired flags the last wait cycle allowed.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // count wait cycles, restart on every ACCESS entry
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master.
// Command in, one APB transfer, response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_en;
  logic   expired;

  assign bus.PRESETn   = ~PRESET;
  assign bus.cmd_ready = (state == IDLE);

  // SETUP always precedes ACCESS, so clear there
  assign cnt_clr = (state == SETUP);
  assign cnt_en  = (state == ACCESS) && !bus.PREADY;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .expired (expired)
  );

  // transfer FSM with registered bus and response outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state           <= IDLE;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= {ADDR_W{1'b0}};
      bus.PWDATA      <= {DATA_W{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_rdata   <= {DATA_W{1'b0}};
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.PWRITE  <= bus.cmd_write;
            bus.PADDR   <= bus.cmd_addr;
            bus.PWDATA  <= bus.cmd_wdata;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.rsp_rdata   <= bus.PWRITE ?
                               {DATA_W{1'b0}} :
                               bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= RESP;
          end else if (expired) begin
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master.
// Inputs change 1ns after posedge; outputs read there too.
module tb_apb_master;

  logic PCLK = 1'b0;
  logic PRESET;
  int   total = 0;
  int   bad   = 0;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    PRESET = 1'b1;
    tick();
    tick();
    total++;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 ||
        bus.PWRITE !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b%b%b exp=000",
               bus.PSEL, bus.PENABLE, bus.PWRITE);
    end
    total++;
    if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus addr=%h wdata=%h exp=0",
               bus.PADDR, bus.PWDATA);
    end
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
        bus.rsp_timeout !== 1'b0 ||
        bus.rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp v=%b e=%b t=%b d=%h exp=0",
               bus.rsp_valid, bus.rsp_err,
               bus.rsp_timeout, bus.rsp_rdata);
    end
    total++;
    if (bus.PRESETn !== 1'b0) begin
      bad++;
      $display("FAIL presetn_rst got=%b exp=0", bus.PRESETn);
    end
    PRESET = 1'b0;
    #1;
    total++;
    if (bus.PRESETn !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset presetn=%b rdy=%b exp=1 1",
               bus.PRESETn, bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h10;
    bus.cmd_wdata = 32'hDEADBEEF;
    bus.PREADY    = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 ||
        bus.PADDR !== 32'h10 || bus.PWRITE !== 1'b1 ||
        bus.PWDATA !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_setup sel=%b en=%b a=%h w=%b d=%h",
               bus.PSEL, bus.PENABLE, bus.PADDR,
               bus.PWRITE, bus.PWDATA);
    end
    tick();
    total++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 ||
        bus.PADDR !== 32'h10 || bus.PWRITE !== 1'b1) begin
      bad++;
      $display("FAIL wr_access sel=%b en=%b a=%h w=%b",
               bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h0 || bus.PSEL !== 1'b0) begin
      bad++;
      $display("FAIL wr_resp v=%b e=%b d=%h sel=%b",
               bus.rsp_valid, bus.rsp_err,
               bus.rsp_rdata, bus.PSEL);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.PADDR !== 32'h10 || bus.PWRITE !== 1'b1) begin
      bad++;
      $display("FAIL wr_idle v=%b rdy=%b a=%h w=%b",
               bus.rsp_valid, bus.cmd_ready,
               bus.PADDR, bus.PWRITE);
    end
  endtask

  task automatic test_wait_read();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h20;
    bus.PREADY    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1 ||
          bus.PADDR !== 32'h20 || bus.PWRITE !== 1'b0) begin
        bad++;
        $display("FAIL rd_wait%0d sel=%b en=%b a=%h w=%b",
                 i, bus.PSEL, bus.PENABLE,
                 bus.PADDR, bus.PWRITE);
      end
      if (i == 3) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h12345678;
      end else begin
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hBAD0BAD0;
      end
      tick();
    end
    bus.PREADY = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b1 ||
        bus.rsp_rdata !== 32'h12345678 ||
        bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp v=%b d=%h e=%b t=%b",
               bus.rsp_valid, bus.rsp_rdata,
               bus.rsp_err, bus.rsp_timeout);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_slverr();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h30;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b1;
    bus.PRDATA    = 32'hA5A5A5A5;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
        bus.rsp_timeout !== 1'b0 ||
        bus.rsp_rdata !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL slverr v=%b e=%b t=%b d=%h",
               bus.rsp_valid, bus.rsp_err,
               bus.rsp_timeout, bus.rsp_rdata);
    end
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'hCAFEF00D;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    n = 0;
    while (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 &&
           n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL to_cycles got=%0d exp=16", n);
    end
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
        bus.rsp_timeout !== 1'b1 ||
        bus.rsp_rdata !== 32'h0 || bus.PSEL !== 1'b0) begin
      bad++;
      $display("FAIL to_resp v=%b e=%b t=%b d=%h sel=%b",
               bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
               bus.rsp_rdata, bus.PSEL);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_ready_at_limit();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h50;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'h0BADCAFE;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL lim_access sel=%b en=%b exp=1 1",
               bus.PSEL, bus.PENABLE);
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h55AA1234;
    tick();
    bus.PREADY = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b0 ||
        bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h55AA1234) begin
      bad++;
      $display("FAIL lim_resp v=%b t=%b e=%b d=%h",
               bus.rsp_valid, bus.rsp_timeout,
               bus.rsp_err, bus.rsp_rdata);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_hold();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h60;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'h00C0FFEE;
    tick();
    tick();
    tick();
    bus.PRDATA  = 32'hFFFFFFFF;
    bus.PSLVERR = 1'b1;
    bus.cmd_addr = 32'h70;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
          bus.rsp_rdata !== 32'h00C0FFEE ||
          bus.rsp_err !== 1'b0 || bus.PSEL !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d v=%b rdy=%b d=%h e=%b sel=%b",
                 i, bus.rsp_valid, bus.cmd_ready,
                 bus.rsp_rdata, bus.rsp_err, bus.PSEL);
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.PADDR !== 32'h60) begin
      bad++;
      $display("FAIL hold_rel v=%b a=%h exp=0 00000060",
               bus.rsp_valid, bus.PADDR);
    end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h80;
    bus.PREADY    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    total++;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 ||
        bus.rsp_valid !== 1'b0 ||
        bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst sel=%b en=%b v=%b rdy=%b",
               bus.PSEL, bus.PENABLE,
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h90;
    bus.cmd_wdata = 32'h11111111;
    bus.PREADY    = 1'b1;
    bus.rsp_ready = 1'b1;
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first rdy=%b exp=1", bus.cmd_ready);
    end
    tick();
    bus.cmd_addr  = 32'hA0;
    bus.cmd_wdata = 32'h22222222;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (bus.cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_busy%0d rdy=%b exp=0",
                 i, bus.cmd_ready);
      end
      tick();
    end
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.PADDR !== 32'h90) begin
      bad++;
      $display("FAIL b2b_n4 rdy=%b a=%h exp=1 00000090",
               bus.cmd_ready, bus.PADDR);
    end
    tick();
    bus.cmd_valid = 1'b0;
    total++;
    if (bus.PSEL !== 1'b1 || bus.PADDR !== 32'hA0 ||
        bus.PWDATA !== 32'h22222222) begin
      bad++;
      $display("FAIL b2b_second sel=%b a=%h d=%h",
               bus.PSEL, bus.PADDR, bus.PWDATA);
    end
    tick();
    tick();
    tick();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_ready_at_limit();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
